// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the byte-enable dual-port RAM
// with its hardware clear sequencer.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clear_state_e;

  function automatic bit latency_ok(input int lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear sequencer: sweeps every word with the clear value after reset and
// on request, and blocks the user ports while the sweep runs.
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDRESS_WID = 4,
  parameter int ADDRESS_MAX = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_we,
  output logic [ADDRESS_WID-1:0] clear_addr
);

  localparam logic [ADDRESS_WID-1:0] LAST_ADDR = ADDRESS_WID'(ADDRESS_MAX - 1);

  clear_state_e           state, state_next;
  logic [ADDRESS_WID-1:0] count, count_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = '0;
    case (state)
      ST_CLEAR: begin
        if (count == LAST_ADDR) state_next = ST_READY;
        else                    count_next = count + ADDRESS_WID'(1);
      end
      ST_READY: begin
        if (clear_req) state_next = ST_CLEAR;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // A reset arriving mid-sweep suppresses that cycle's write; the sweep restarts.
  always_comb begin
    clear_busy = (state == ST_CLEAR);
    clear_we   = clear_busy && !reset;
    clear_addr = count;
  end

endmodule

// File: rtl/ram_dp_be_clear.sv
// Simple dual-port RAM with per-byte write enables, 1- or 2-cycle read
// latency, selectable read-during-write result and a hardware clear sweep.
module ram_dp_be_clear
  import ram_pkg::*;
#(
  parameter int                  DATA_WID     = 16,
  parameter int                  BYTE_WID     = 8,
  parameter int                  ADDRESS_WID  = 4,
  parameter int                  ADDRESS_MAX  = 16,
  parameter int                  READ_LATENCY = 1,
  parameter int                  RDW_MODE     = RDW_OLD,
  parameter logic [DATA_WID-1:0] CLEAR_VALUE  = '0,
  localparam int                 NUM_BYTES    = DATA_WID / BYTE_WID
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDRESS_WID-1:0] address_write,
  input  logic [DATA_WID-1:0]    data_write,
  input  logic                   write_enable,
  input  logic [NUM_BYTES-1:0]   byte_enable,
  input  logic [ADDRESS_WID-1:0] address_read,
  input  logic                   read_enable,
  output logic [DATA_WID-1:0]    data_read,
  output logic                   read_valid,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   addr_error
);

  localparam logic [ADDRESS_WID:0] ADDR_LIMIT = (ADDRESS_WID + 1)'(ADDRESS_MAX);
  // Unsupported latencies fall back to the single-stage pipeline.
  localparam bit TWO_STAGE    = latency_ok(READ_LATENCY) && (READ_LATENCY == LATENCY_MAX);
  localparam bit RDW_NEW_DATA = (RDW_MODE == RDW_NEW);

  logic [DATA_WID-1:0] mem [ADDRESS_MAX];

  logic                   clear_we;
  logic [ADDRESS_WID-1:0] clear_addr;

  ram_clear_ctrl #(
    .ADDRESS_WID (ADDRESS_WID),
    .ADDRESS_MAX (ADDRESS_MAX)
  ) u_clear_ctrl (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  logic                ready;
  logic                wr_in_range, rd_in_range;
  logic                wr_accept, rd_accept, err_now;
  logic [DATA_WID-1:0] rd_word;

  always_comb begin
    ready       = !clear_busy && !reset;
    wr_in_range = ({1'b0, address_write} < ADDR_LIMIT);
    rd_in_range = ({1'b0, address_read}  < ADDR_LIMIT);
    wr_accept   = ready && write_enable && wr_in_range;
    rd_accept   = ready && read_enable;
    err_now     = ready && ((write_enable && !wr_in_range) || (read_enable && !rd_in_range));
    rd_word     = '0;
    if (rd_in_range) begin
      rd_word = mem[address_read];
      if (RDW_NEW_DATA && wr_accept && (address_write == address_read)) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (byte_enable[i]) rd_word[i*BYTE_WID +: BYTE_WID] = data_write[i*BYTE_WID +: BYTE_WID];
        end
      end
    end
  end

  // NOTE: the array has no reset; the clear sweep initialises it, which keeps
  // it mappable onto RAM macros.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_addr] <= CLEAR_VALUE;
    end else if (wr_accept) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (byte_enable[i]) mem[address_write][i*BYTE_WID +: BYTE_WID] <= data_write[i*BYTE_WID +: BYTE_WID];
      end
    end
  end

  // Write errors travel with the read pipeline so errors from one cycle
  // always merge into a single pulse aligned with that cycle's read result.
  logic                pipe_valid, pipe_err;
  logic [DATA_WID-1:0] pipe_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_err   <= 1'b0;
      pipe_data  <= '0;
    end else begin
      pipe_valid <= rd_accept;
      pipe_err   <= err_now;
      if (rd_accept) pipe_data <= rd_word;
    end
  end

  logic                out_valid_d, out_err_d;
  logic [DATA_WID-1:0] out_data_d;

  always_comb begin
    out_valid_d = TWO_STAGE ? pipe_valid : rd_accept;
    out_err_d   = TWO_STAGE ? pipe_err   : err_now;
    out_data_d  = TWO_STAGE ? pipe_data  : rd_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_valid <= 1'b0;
      addr_error <= 1'b0;
      data_read  <= '0;
    end else begin
      read_valid <= out_valid_d;
      addr_error <= out_err_d;
      if (out_valid_d) data_read <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ram_dp_be_clear.sv
// Bench: two RAM configurations driven by shared stimulus, each checked every
// cycle against a behavioural model, plus hand-computed directed expectations.
module tb_ram_dp_be_clear;

  localparam int          A_AMAX = 16;
  localparam int          B_AMAX = 12;
  localparam logic [15:0] B_CV   = 16'h5A3C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address_write = '0, address_read = '0;
  logic [15:0] data_write = '0;
  logic [1:0]  byte_enable = '0;
  logic        write_enable = 1'b0, read_enable = 1'b0, clear_req = 1'b0;

  logic [15:0] data_read_a, data_read_b;
  logic        read_valid_a, read_valid_b, clear_busy_a, clear_busy_b, addr_error_a, addr_error_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit live = 1'b0;

  always #5 clk = ~clk;

  ram_dp_be_clear #(
    .DATA_WID(16), .BYTE_WID(8), .ADDRESS_WID(4), .ADDRESS_MAX(A_AMAX),
    .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_VALUE(16'h0000)
  ) u_a (
    .clk(clk), .reset(reset), .address_write(address_write), .data_write(data_write),
    .write_enable(write_enable), .byte_enable(byte_enable), .address_read(address_read),
    .read_enable(read_enable), .data_read(data_read_a), .read_valid(read_valid_a),
    .clear_req(clear_req), .clear_busy(clear_busy_a), .addr_error(addr_error_a)
  );

  ram_dp_be_clear #(
    .DATA_WID(16), .BYTE_WID(8), .ADDRESS_WID(4), .ADDRESS_MAX(B_AMAX),
    .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_VALUE(B_CV)
  ) u_b (
    .clk(clk), .reset(reset), .address_write(address_write), .data_write(data_write),
    .write_enable(write_enable), .byte_enable(byte_enable), .address_read(address_read),
    .read_enable(read_enable), .data_read(data_read_b), .read_valid(read_valid_b),
    .clear_req(clear_req), .clear_busy(clear_busy_b), .addr_error(addr_error_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int amax_of(input int k);
    return (k == 0) ? A_AMAX : B_AMAX;
  endfunction
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic bit rdw_new_of(input int k);
    return k == 1;
  endfunction
  function automatic logic [15:0] cv_of(input int k);
    return (k == 0) ? 16'h0000 : B_CV;
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  logic [15:0] mm [2][16];
  int          clr_left [2];
  bit          sv [2][4];
  bit          se [2][4];
  logic [15:0] sd [2][4];
  bit          e_valid [2], e_err [2], e_busy [2];
  logic [15:0] e_data [2];

  // Results are scheduled into a small ring indexed by the edge they appear at.
  task automatic model_step(input int k);
    int s_in, s_out;
    bit wr_in, rd_in, wr_ok, err;
    logic [15:0] word;
    s_out = cyc % 4;
    if (reset) begin
      clr_left[k] = amax_of(k);
      for (int s = 0; s < 4; s++) begin
        sv[k][s] = 1'b0;
        se[k][s] = 1'b0;
      end
      e_valid[k] = 1'b0;
      e_err[k]   = 1'b0;
      e_data[k]  = 16'h0000;
      e_busy[k]  = 1'b1;
      return;
    end
    s_in = (cyc + lat_of(k) - 1) % 4;
    if (clr_left[k] > 0) begin
      mm[k][amax_of(k) - clr_left[k]] = cv_of(k);
      clr_left[k]--;
    end else begin
      wr_in = int'(address_write) < amax_of(k);
      rd_in = int'(address_read) < amax_of(k);
      wr_ok = write_enable && wr_in;
      err   = (write_enable && !wr_in) || (read_enable && !rd_in);
      if (read_enable) begin
        word = rd_in ? mm[k][address_read] : 16'h0000;
        if (rd_in && rdw_new_of(k) && wr_ok && address_write == address_read)
          word = merge(word, data_write, byte_enable);
        sv[k][s_in] = 1'b1;
        sd[k][s_in] = word;
      end
      if (err) se[k][s_in] = 1'b1;
      if (wr_ok) mm[k][address_write] = merge(mm[k][address_write], data_write, byte_enable);
      if (clear_req) clr_left[k] = amax_of(k);
    end
    e_valid[k] = sv[k][s_out];
    e_err[k]   = se[k][s_out];
    if (sv[k][s_out]) e_data[k] = sd[k][s_out];
    sv[k][s_out] = 1'b0;
    se[k][s_out] = 1'b0;
    e_busy[k] = clr_left[k] > 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) live = 1'b1;
    model_step(0);
    model_step(1);
  end

  // ---------------- compare and capture ----------------
  typedef struct {
    logic [15:0] data;
    logic        err;
    int          at;
  } rd_t;

  rd_t qa[$];
  rd_t qb[$];
  int  errs_a = 0, errs_b = 0;

  always @(negedge clk) begin
    if (live) begin
      check("a_busy",  clear_busy_a, e_busy[0]);
      check("a_valid", read_valid_a, e_valid[0]);
      check("a_err",   addr_error_a, e_err[0]);
      check("a_data",  data_read_a,  e_data[0]);
      check("b_busy",  clear_busy_b, e_busy[1]);
      check("b_valid", read_valid_b, e_valid[1]);
      check("b_err",   addr_error_b, e_err[1]);
      check("b_data",  data_read_b,  e_data[1]);
    end
    if (read_valid_a === 1'b1) qa.push_back('{data_read_a, addr_error_a, cyc});
    if (read_valid_b === 1'b1) qb.push_back('{data_read_b, addr_error_b, cyc});
    if (addr_error_a === 1'b1) errs_a++;
    if (addr_error_b === 1'b1) errs_b++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    clear_req    = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    address_write = a;
    data_write    = d;
    byte_enable   = be;
    write_enable  = 1'b1;
    tick();
    write_enable  = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    address_read = a;
    read_enable  = 1'b1;
    tick();
    read_enable  = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while ((clear_busy_a || clear_busy_b) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check(name, clear_busy_a | clear_busy_b, 1'b0);
  endtask

  task automatic busy_len(input string name, input int exp_a, input int exp_b);
    int cnt_a = 0, cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt_a += int'(clear_busy_a);
      cnt_b += int'(clear_busy_b);
    end
    check({name, "_a"}, cnt_a, exp_a);
    check({name, "_b"}, cnt_b, exp_b);
    tick();
  endtask

  task automatic expect_one(input string name, input logic [15:0] ea, input logic [15:0] eb);
    check({name, "_cnt_a"}, qa.size(), 1);
    check({name, "_cnt_b"}, qb.size(), 1);
    if (qa.size() > 0) check({name, "_a"}, qa[0].data, ea);
    if (qb.size() > 0) check({name, "_b"}, qb[0].data, eb);
  endtask

  task automatic read_all_expect(input string name, input logic [15:0] ea, input logic [15:0] eb);
    qa.delete();
    qb.delete();
    for (int a = 0; a < 16; a++) do_read(4'(a));
    drain();
    check({name, "_cnt_a"}, qa.size(), 16);
    check({name, "_cnt_b"}, qb.size(), 16);
    for (int i = 0; i < 16 && i < qa.size() && i < qb.size(); i++) begin
      check({name, "_a"}, qa[i].data, ea);
      check({name, "_b"}, qb[i].data, (i < B_AMAX) ? eb : 16'h0000);
      check({name, "_b_err"}, qb[i].err, i >= B_AMAX);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0;

    // Reset and the power-on clear sweep.
    idle();
    tick();
    tick();
    check("rst_busy_a",  clear_busy_a, 1'b1);
    check("rst_valid_a", read_valid_a, 1'b0);
    check("rst_data_b",  data_read_b,  16'h0000);
    check("rst_err_b",   addr_error_b, 1'b0);
    reset = 1'b0;
    busy_len("boot_busy", 16, 12);

    // Every word holds the clear value; also pins latency and throughput.
    qa.delete();
    qb.delete();
    c0 = cyc;
    for (int a = 0; a < 4; a++) do_read(4'(a));
    drain();
    check("lat_cnt_b", qb.size(), 4);
    for (int i = 0; i < 4 && i < qa.size() && i < qb.size(); i++) begin
      check("lat_a", qa[i].at - c0, 1 + i);
      check("lat_b", qb[i].at - c0, 2 + i);
    end
    read_all_expect("boot_read", 16'h0000, B_CV);

    // Byte enables.
    do_write(4'd3, 16'hABCD, 2'b11);
    do_write(4'd3, 16'h1234, 2'b01);
    do_write(4'd3, 16'hFFFF, 2'b00);
    qa.delete(); qb.delete();
    do_read(4'd3);
    drain();
    expect_one("be_merge", 16'hAB34, 16'hAB34);

    // Read during write, same address.
    do_write(4'd7, 16'h1111, 2'b11);
    qa.delete(); qb.delete();
    address_write = 4'd7; data_write = 16'h5555; byte_enable = 2'b11; write_enable = 1'b1;
    address_read  = 4'd7; read_enable = 1'b1;
    tick();
    idle();
    drain();
    expect_one("rdw", 16'h1111, 16'h5555);
    qa.delete(); qb.delete();
    do_read(4'd7);
    drain();
    expect_one("rdw_after", 16'h5555, 16'h5555);

    // Out-of-range write and read in the same cycle (only B is 12 deep).
    qa.delete(); qb.delete();
    errs_a = 0; errs_b = 0;
    address_write = 4'd13; data_write = 16'hBEEF; byte_enable = 2'b11; write_enable = 1'b1;
    address_read  = 4'd14; read_enable = 1'b1;
    tick();
    idle();
    drain();
    expect_one("range", 16'h0000, 16'h0000);
    if (qb.size() > 0) check("range_err_b", qb[0].err, 1'b1);
    check("range_pulses_b", errs_b, 1);
    check("range_pulses_a", errs_a, 0);
    qa.delete(); qb.delete();
    do_read(4'd13);
    drain();
    expect_one("range_13", 16'hBEEF, 16'h0000);

    // Clear on request with traffic while busy.
    for (int a = 0; a < 16; a++) do_write(4'(a), 16'hFFFF, 2'b11);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    qa.delete(); qb.delete();
    for (int i = 0; i < 8; i++) begin
      address_write = 4'($urandom_range(0, 15));
      address_read  = 4'($urandom_range(0, 15));
      data_write    = 16'($urandom);
      byte_enable   = 2'b11;
      write_enable  = 1'b1;
      read_enable   = 1'b1;
      tick();
    end
    idle();
    wait_ready("clear_timeout");
    check("busy_reads_a", qa.size(), 0);
    check("busy_reads_b", qb.size(), 0);
    read_all_expect("clear_read", 16'h0000, B_CV);

    // Reset five cycles into a requested sweep restarts it from address 0.
    for (int a = 0; a < 16; a++) do_write(4'(a), 16'hFFFF, 2'b11);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_len("restart_busy", 16, 12);
    read_all_expect("restart_read", 16'h0000, B_CV);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(0, 255) == 0);
      clear_req     = ($urandom_range(0, 63) == 0);
      write_enable  = 1'($urandom_range(0, 1));
      read_enable   = 1'($urandom_range(0, 1));
      address_write = 4'($urandom_range(0, 15));
      address_read  = ($urandom_range(0, 3) == 0) ? address_write : 4'($urandom_range(0, 15));
      byte_enable   = 2'($urandom);
      data_write    = 16'($urandom);
      tick();
    end
    reset = 1'b0;
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
